// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between the ALU writeback path
// (source 0) and the memory-load writeback path (source 1). Each source feeds
// a one-entry holding slot. A round-robin arbiter drains the slots into a
// registered write port. pendingMask reports every register that has a write
// queued in a slot or currently on the write port.
//
// Handshake (both sources): a transfer happens on a rising clk edge when
// xValid && xReady. xReady = !xFull || xGrant, so it is a function of
// registered state only and never looks at xValid. A full slot that is being
// granted may accept a new entry on the same edge (drain and refill). A
// source must hold Reg/Data stable while Valid && !Ready.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  aluValid,
  output logic                  aluReady,
  input  logic [ADDR_WIDTH-1:0] aluReg,
  input  logic [DATA_WIDTH-1:0] aluData,
  input  logic                  memValid,
  output logic                  memReady,
  input  logic [ADDR_WIDTH-1:0] memReg,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [ADDR_WIDTH-1:0] writeRegister,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  regWrite,
  output logic [NUM_REGS-1:0]   pendingMask
);

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // ALU holding slot
  logic                  r_alu_full;
  logic [ADDR_WIDTH-1:0] r_alu_reg;
  logic [DATA_WIDTH-1:0] r_alu_data;

  // Memory-load holding slot
  logic                  r_mem_full;
  logic [ADDR_WIDTH-1:0] r_mem_reg;
  logic [DATA_WIDTH-1:0] r_mem_data;

  // Round-robin pointer: source preferred when both slots are full
  logic                  r_rr_ptr;

  // Registered write port
  logic [ADDR_WIDTH-1:0] r_write_register;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic                  r_reg_write;

  logic                  w_alu_grant;
  logic                  w_mem_grant;
  logic                  w_any_grant;
  logic                  w_alu_ready;
  logic                  w_mem_ready;
  logic                  w_alu_take;
  logic                  w_mem_take;
  logic [ADDR_WIDTH-1:0] w_grant_reg;
  logic [DATA_WIDTH-1:0] w_grant_data;
  logic [NUM_REGS-1:0]   w_alu_onehot;
  logic [NUM_REGS-1:0]   w_mem_onehot;
  logic [NUM_REGS-1:0]   w_out_onehot;

  localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  // Arbitration: a lone full slot wins; with both full the pointer decides
  always_comb begin
    w_alu_grant = r_alu_full && (!r_mem_full || (r_rr_ptr == SRC_ALU));
    w_mem_grant = r_mem_full && (!r_alu_full || (r_rr_ptr == SRC_MEM));
    w_any_grant = w_alu_grant || w_mem_grant;
  end

  // Ready depends only on slot occupancy and the grant, never on valid
  always_comb begin
    w_alu_ready = !r_alu_full || w_alu_grant;
    w_mem_ready = !r_mem_full || w_mem_grant;
    w_alu_take  = aluValid && w_alu_ready;
    w_mem_take  = memValid && w_mem_ready;
  end

  // Select the granted slot's contents for the write port
  always_comb begin
    w_grant_reg  = r_alu_reg;
    w_grant_data = r_alu_data;
    if (w_mem_grant) begin
      w_grant_reg  = r_mem_reg;
      w_grant_data = r_mem_data;
    end
  end

  // ALU slot: fill on transfer (also when draining the same edge), else empty on grant
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_alu_full <= 1'b0;
      r_alu_reg  <= '0;
      r_alu_data <= '0;
    end else if (w_alu_take) begin
      r_alu_full <= 1'b1;
      r_alu_reg  <= aluReg;
      r_alu_data <= aluData;
    end else if (w_alu_grant) begin
      r_alu_full <= 1'b0;
    end
  end

  // Memory slot: fill on transfer (also when draining the same edge), else empty on grant
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_mem_full <= 1'b0;
      r_mem_reg  <= '0;
      r_mem_data <= '0;
    end else if (w_mem_take) begin
      r_mem_full <= 1'b1;
      r_mem_reg  <= memReg;
      r_mem_data <= memData;
    end else if (w_mem_grant) begin
      r_mem_full <= 1'b0;
    end
  end

  // Round-robin pointer moves to the source that was not just granted
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rr_ptr <= SRC_ALU;
    end else if (w_alu_grant) begin
      r_rr_ptr <= SRC_MEM;
    end else if (w_mem_grant) begin
      r_rr_ptr <= SRC_ALU;
    end
  end

  // Write port: load the granted entry; index/data hold when idle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_reg_write      <= 1'b0;
      r_write_register <= '0;
      r_write_data     <= '0;
    end else if (w_any_grant) begin
      r_reg_write      <= 1'b1;
      r_write_register <= w_grant_reg;
      r_write_data     <= w_grant_data;
    end else begin
      r_reg_write      <= 1'b0;
    end
  end

  // Pending registers: anything sitting in a slot or on the write port
  always_comb begin
    w_alu_onehot = r_alu_full  ? (ONE << r_alu_reg)        : '0;
    w_mem_onehot = r_mem_full  ? (ONE << r_mem_reg)        : '0;
    w_out_onehot = r_reg_write ? (ONE << r_write_register) : '0;
    pendingMask  = w_alu_onehot | w_mem_onehot | w_out_onehot;
  end

  assign aluReady      = w_alu_ready;
  assign memReady      = w_mem_ready;
  assign writeRegister = r_write_register;
  assign writeData     = r_write_data;
  assign regWrite      = r_reg_write;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        resetN;
  logic        aluValid;
  logic        aluReady;
  logic [4:0]  aluReg;
  logic [31:0] aluData;
  logic        memValid;
  logic        memReady;
  logic [4:0]  memReg;
  logic [31:0] memData;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        regWrite;
  logic [31:0] pendingMask;

  int n_assert = 0;
  int n_fail   = 0;

  // Register file model and a log of issued writes
  logic [31:0] rf [32];
  logic [4:0]  log_reg[$];
  logic [31:0] log_data[$];

  regfile_write_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS  (32)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .aluValid     (aluValid),
    .aluReady     (aluReady),
    .aluReg       (aluReg),
    .aluData      (aluData),
    .memValid     (memValid),
    .memReady     (memReady),
    .memReg       (memReg),
    .memData      (memData),
    .writeRegister(writeRegister),
    .writeData    (writeData),
    .regWrite     (regWrite),
    .pendingMask  (pendingMask)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file captures one edge after the write port shows the write
  always @(posedge clk) begin
    if (regWrite) rf[writeRegister] <= writeData;
  end

  // Log every write-port pulse once, mid-cycle
  always @(negedge clk) begin
    if (resetN && regWrite) begin
      log_reg.push_back(writeRegister);
      log_data.push_back(writeData);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aluValid = 1'b0;
    aluReg   = '0;
    aluData  = '0;
    memValid = 1'b0;
    memReg   = '0;
    memData  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    log_reg.delete();
    log_data.delete();
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && log_reg.size() < n; k++) tick();
    check(tag, 64'(log_reg.size() >= n), 64'd1);
  endtask

  initial begin
    logic [4:0]  a_regs [3];
    logic [4:0]  m_regs [3];
    logic [4:0]  exp_order [6];
    int          ai;
    int          mi;
    int          alu_stall;
    int          mem_stall;
    int          max_stall;
    logic        alu_acc;
    logic        mem_acc;
    logic [31:0] exp_mask;

    for (int r = 0; r < 32; r++) rf[r] = 32'h0;
    idle_inputs();
    resetN = 1'b0;
    #12;

    // ---------- reset state ----------
    check("rst_regWrite",      64'(regWrite),      64'd0);
    check("rst_writeRegister", 64'(writeRegister), 64'd0);
    check("rst_writeData",     64'(writeData),     64'd0);
    check("rst_pendingMask",   64'(pendingMask),   64'd0);
    check("rst_aluReady",      64'(aluReady),      64'd1);
    check("rst_memReady",      64'(memReady),      64'd1);
    @(posedge clk);
    #1;
    resetN = 1'b1;

    // ---------- single ALU write, latency ----------
    aluValid = 1'b1; aluReg = 5'd5; aluData = 32'hDEADBEEF;
    tick();                                   // edge 1: accepted
    aluValid = 1'b0;
    check("lat_e1_regWrite", 64'(regWrite),    64'd0);
    check("lat_e1_pending",  64'(pendingMask), 64'h20);
    tick();                                   // edge 2
    check("lat_e2_regWrite", 64'(regWrite),      64'd1);
    check("lat_e2_wreg",     64'(writeRegister), 64'd5);
    check("lat_e2_wdata",    64'(writeData),     64'hDEADBEEF);
    check("lat_e2_pending",  64'(pendingMask),   64'h20);
    tick();                                   // edge 3: file written
    check("lat_e3_regWrite", 64'(regWrite),    64'd0);
    check("lat_e3_pending",  64'(pendingMask), 64'd0);
    check("lat_e3_rf5",      64'(rf[5]),       64'hDEADBEEF);
    check("lat_e3_wdata_hold", 64'(writeData), 64'hDEADBEEF);

    // ---------- both sources busy: alternating grants ----------
    do_reset();
    a_regs = '{5'd1, 5'd2, 5'd3};
    m_regs = '{5'd9, 5'd10, 5'd11};
    exp_order = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
    ai = 0; mi = 0; alu_stall = 0; mem_stall = 0; max_stall = 0;
    for (int c = 0; c < 20 && (ai < 3 || mi < 3); c++) begin
      aluValid = (ai < 3);
      aluReg   = (ai < 3) ? a_regs[ai] : 5'd0;
      aluData  = 32'hA000 + 32'(aluReg);
      memValid = (mi < 3);
      memReg   = (mi < 3) ? m_regs[mi] : 5'd0;
      memData  = 32'hB000 + 32'(memReg);
      alu_acc  = aluValid && aluReady;
      mem_acc  = memValid && memReady;
      alu_stall = (aluValid && !aluReady) ? alu_stall + 1 : 0;
      mem_stall = (memValid && !memReady) ? mem_stall + 1 : 0;
      if (alu_stall > max_stall) max_stall = alu_stall;
      if (mem_stall > max_stall) max_stall = mem_stall;
      tick();
      if (alu_acc) ai++;
      if (mem_acc) mi++;
    end
    idle_inputs();
    check("rr_all_accepted", 64'(ai + mi), 64'd6);
    check("rr_max_stall_le1", 64'(max_stall <= 1), 64'd1);
    wait_log(6, 20, "rr_log_timeout");
    for (int k = 0; k < 6; k++) begin
      if (k < log_reg.size()) begin
        check($sformatf("rr_order_%0d", k), 64'(log_reg[k]), 64'(exp_order[k]));
        check($sformatf("rr_data_%0d", k), 64'(log_data[k]),
              64'((exp_order[k] < 5'd9 ? 32'hA000 : 32'hB000) + 32'(exp_order[k])));
      end
    end

    // ---------- same register from both, rrPtr = mem ----------
    do_reset();
    aluValid = 1'b1; aluReg = 5'd3; aluData = 32'h33;  // one ALU grant moves pointer to mem
    tick();
    idle_inputs();
    wait_log(1, 10, "same_pre_timeout");
    tick();
    tick();
    log_reg.delete();
    log_data.delete();
    aluValid = 1'b1; aluReg = 5'd7; aluData = 32'h11;
    memValid = 1'b1; memReg = 5'd7; memData = 32'h22;
    tick();
    idle_inputs();
    check("same_pending7", 64'(pendingMask), 64'h80);
    wait_log(2, 10, "same_log_timeout");
    tick();
    tick();
    if (log_data.size() >= 2) begin
      check("same_first_mem",  64'(log_data[0]), 64'h22);
      check("same_second_alu", 64'(log_data[1]), 64'h11);
    end
    check("same_rf7",     64'(rf[7]),       64'h11);
    check("same_pending", 64'(pendingMask), 64'd0);

    // ---------- ALU streams 8 writes, no bubbles; regs 0 and 31 included ----------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      aluValid = 1'b1;
      aluReg   = (i == 0) ? 5'd0 : (i == 7) ? 5'd31 : 5'(i + 15);
      aluData  = 32'h5000 + 32'(i);
      check($sformatf("stream_ready_%0d", i), 64'(aluReady), 64'd1);
      tick();
      if (i >= 1) check($sformatf("stream_regWrite_%0d", i), 64'(regWrite), 64'd1);
    end
    idle_inputs();
    tick();
    check("stream_last_regWrite", 64'(regWrite),      64'd1);
    check("stream_last_wreg",     64'(writeRegister), 64'd31);
    tick();
    check("stream_end_regWrite",  64'(regWrite),   64'd0);
    check("stream_count",         64'(log_reg.size()), 64'd8);
    check("stream_rf0",           64'(rf[0]),      64'h5000);
    check("stream_rf31",          64'(rf[31]),     64'h5007);

    // ---------- asynchronous reset mid-operation ----------
    do_reset();
    aluValid = 1'b1; aluReg = 5'd12; aluData = 32'hC12;
    memValid = 1'b1; memReg = 5'd13; memData = 32'hC13;
    tick();                                   // both slots fill
    memValid = 1'b0;
    aluReg = 5'd14; aluData = 32'hC14;        // ALU drains and refills
    tick();
    aluValid = 1'b0;
    check("arst_pre_regWrite", 64'(regWrite), 64'd1);
    exp_mask = (32'd1 << 12) | (32'd1 << 13) | (32'd1 << 14);
    check("arst_pre_pending", 64'(pendingMask), 64'(exp_mask));
    #2;
    resetN = 1'b0;
    #1;
    check("arst_regWrite",  64'(regWrite),      64'd0);
    check("arst_pending",   64'(pendingMask),   64'd0);
    check("arst_wreg",      64'(writeRegister), 64'd0);
    log_reg.delete();
    log_data.delete();
    @(posedge clk);
    #1;
    resetN = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("arst_no_write_after", 64'(log_reg.size()), 64'd0);

    // ---------- held valid on a full, ungranted mem slot ----------
    do_reset();
    aluValid = 1'b1; aluReg = 5'd20; aluData = 32'h2020;
    memValid = 1'b1; memReg = 5'd21; memData = 32'h100;
    tick();                                   // both full, ALU granted
    aluValid = 1'b0;
    memReg = 5'd22; memData = 32'h200;        // new request held on mem
    check("hold_memReady0", 64'(memReady), 64'd0);
    exp_mask = (32'd1 << 20) | (32'd1 << 21);
    check("hold_pending", 64'(pendingMask), 64'(exp_mask));
    tick();                                   // ALU issued, mem now granted
    check("hold_memReady1", 64'(memReady), 64'd1);
    tick();                                   // mem drains 21 and takes 22
    memValid = 1'b0;
    wait_log(3, 10, "hold_log_timeout");
    tick();
    tick();
    if (log_reg.size() >= 3) begin
      check("hold_order0", 64'(log_reg[0]),  64'd20);
      check("hold_order1", 64'(log_reg[1]),  64'd21);
      check("hold_data1",  64'(log_data[1]), 64'h100);
      check("hold_order2", 64'(log_reg[2]),  64'd22);
      check("hold_data2",  64'(log_data[2]), 64'h200);
    end
    check("hold_rf21", 64'(rf[21]), 64'h100);
    check("hold_rf22", 64'(rf[22]), 64'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
